// File: rtl/arith_pkg.sv
// Shared arithmetic-unit types and helpers for the iterative multiplier and divider.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } divider_state_t;

    // Bits needed for an iteration counter spanning 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bundle for seq_divider.
interface seq_divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             dbz;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, dbz
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, dbz
    );
endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] r,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] r_next,
    output logic             q_bit
);
    logic [WIDTH:0] t;

    assign t     = {r, q_msb};
    assign q_bit = (t >= {1'b0, divisor});
    // Any result of the subtraction is below divisor, so the low WIDTH bits are exact.
    assign r_next = q_bit ? (t[WIDTH-1:0] - divisor) : t[WIDTH-1:0];
endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per cycle, start/done handshake.
// Optional divide-by-zero short-cut and flag enabled by defining DIVIDER_DBZ_EN.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one shift-subtract iteration per cycle, WIDTH cycles
// DONE  | one-cycle done pulse, results valid
module seq_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    seq_divider_if.slave bus
);
    localparam int               CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    divider_state_t   state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] r, q, dvs;
    logic [WIDTH-1:0] quotient_q, remainder_q;
    logic [WIDTH-1:0] r_next;
    logic             q_bit;
    logic             zero_div;
    logic             busy, done;

`ifdef DIVIDER_DBZ_EN
    logic dbz_q;
    assign zero_div = (bus.divisor == '0);
`else
    assign zero_div = 1'b0;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .r       (r),
        .q_msb   (q[WIDTH-1]),
        .divisor (dvs),
        .r_next  (r_next),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = zero_div ? DONE : RUN;
            RUN:     if (cnt == LAST) state_next = DONE;
            DONE:    state_next = bus.start ? (zero_div ? DONE : RUN) : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            r           <= '0;
            q           <= '0;
            dvs         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else if (state == RUN) begin
            r <= r_next;
            q <= {q[WIDTH-2:0], q_bit};
            if (cnt == LAST) begin
                cnt         <= '0;
                quotient_q  <= {q[WIDTH-2:0], q_bit};
                remainder_q <= r_next;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end else if (bus.start) begin
            cnt <= '0;
            r   <= '0;
            q   <= bus.dividend;
            dvs <= bus.divisor;
            // Divide-by-zero skips RUN, so publish the natural all-ones result now.
            if (zero_div) begin
                quotient_q  <= '1;
                remainder_q <= bus.dividend;
            end
        end
    end

`ifdef DIVIDER_DBZ_EN
    always_ff @(posedge clk) begin
        if (rst)                           dbz_q <= 1'b0;
        else if (state != RUN && bus.start) dbz_q <= zero_div;
    end
    assign bus.dbz = dbz_q;
`else
    assign bus.dbz = 1'b0;
`endif

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;

`ifdef FORMAL
    logic [WIDTH-1:0] dvd_cap;
    always_ff @(posedge clk) begin
        if (rst)                            dvd_cap <= '0;
        else if (state != RUN && bus.start) dvd_cap <= bus.dividend;
    end

    always_comb begin
        if (state == DONE) begin
            assert ((2*WIDTH)'(quotient_q) * (2*WIDTH)'(dvs) + (2*WIDTH)'(remainder_q)
                    == (2*WIDTH)'(dvd_cap));
            if (dvs != '0) assert (remainder_q < dvs);
        end
        assert (cnt <= LAST);
        assert (!(busy && done));
    end
`endif
endmodule
